// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit FIFO and its send sequencer:
// sequencer state encoding, ASCII line-ending constants and the ARM timeout.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        DRAIN   = 2'd2,
        CR_PEND = 2'd3
    } tx_state_t;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    // Cycles the sequencer waits in ARM for the transmitter to raise busy.
    localparam int ARM_TIMEOUT = 4;
    localparam int ARM_CNT_W   = $clog2(ARM_TIMEOUT);
    localparam logic [ARM_CNT_W-1:0] ARM_LAST = ARM_CNT_W'(ARM_TIMEOUT - 1);

    // True when a byte must be expanded into a CR/LF pair.
    function automatic logic is_lf(input logic [7:0] b);
        return (b == ASCII_LF);
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Byte FIFO for the UART transmit path: register-array storage, wrap-bit
// pointers, full/empty/level flags and a one-cycle overflow pulse for pushes
// dropped while full. A push into a full FIFO is still accepted when a pop
// happens in the same cycle. Reads are combinational from mem[rd_ptr].
module sync_fifo
    import uart_pkg::*;
#(
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow
);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        push;
    logic        pop;
    logic        drop;

    assign pop     = rd_en && !empty;
    assign push    = wr_en && (!full || pop);
    assign drop    = wr_en && full && !pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointer advance on accepted push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Overflow pulse for the cycle after a push was dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else begin
            overflow <= drop;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit FIFO with send sequencer. Bytes pushed by the producer are
// buffered in sync_fifo and handed to the transmitter one at a time using a
// single-cycle tx_send strobe with registered tx_data, respecting tx_busy.
// Optional build macro UART_TX_FIFO_CRLF_EN: a popped LF (8'h0A) is sent as
// CR (8'h0D) followed by LF, the LF being held in a staging register.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          tx_send,
    output logic [7:0]    tx_data,
    input  logic          tx_busy
);

    tx_state_t               state;
    tx_state_t               state_nxt;
    logic [ARM_CNT_W-1:0]    arm_cnt;
    logic [ARM_CNT_W-1:0]    arm_cnt_nxt;
    logic                    send_nxt;
    logic [7:0]              data_nxt;
    logic                    rd_en;
    logic [7:0]              fifo_data;
    tx_state_t               after_frame;

`ifdef UART_TX_FIFO_CRLF_EN
    logic [7:0]              stage;
    logic [7:0]              stage_nxt;
    logic                    stage_vld;
    logic                    stage_vld_nxt;
`endif

    sync_fifo #(
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_data  (fifo_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow)
    );

    // Where a finished (or abandoned) frame leads: a staged LF goes next.
`ifdef UART_TX_FIFO_CRLF_EN
    assign after_frame = stage_vld ? CR_PEND : IDLE;
`else
    assign after_frame = IDLE;
`endif

    // Sequencer next-state, pop request and next send strobe/data.
    always_comb begin
        state_nxt   = state;
        arm_cnt_nxt = arm_cnt;
        send_nxt    = 1'b0;
        data_nxt    = tx_data;
        rd_en       = 1'b0;
`ifdef UART_TX_FIFO_CRLF_EN
        stage_nxt     = stage;
        stage_vld_nxt = stage_vld;
`endif
        case (state)
            IDLE: begin
                if (!empty && !tx_busy) begin
                    rd_en       = 1'b1;
                    send_nxt    = 1'b1;
                    data_nxt    = fifo_data;
                    arm_cnt_nxt = '0;
                    state_nxt   = ARM;
`ifdef UART_TX_FIFO_CRLF_EN
                    if (is_lf(fifo_data)) begin
                        data_nxt      = ASCII_CR;
                        stage_nxt     = ASCII_LF;
                        stage_vld_nxt = 1'b1;
                    end
`endif
                end
            end
            ARM: begin
                if (tx_busy) begin
                    state_nxt = DRAIN;
                end else if (arm_cnt == ARM_LAST) begin
                    state_nxt = after_frame;
                end else begin
                    arm_cnt_nxt = arm_cnt + 1'b1;
                end
            end
            DRAIN: begin
                if (!tx_busy) begin
                    state_nxt = after_frame;
                end
            end
            CR_PEND: begin
`ifdef UART_TX_FIFO_CRLF_EN
                // Send the staged LF without touching the FIFO.
                if (!tx_busy) begin
                    send_nxt      = 1'b1;
                    data_nxt      = stage;
                    stage_vld_nxt = 1'b0;
                    arm_cnt_nxt   = '0;
                    state_nxt     = ARM;
                end
`else
                state_nxt = IDLE;
`endif
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Sequencer state and ARM timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            arm_cnt <= '0;
        end else begin
            state   <= state_nxt;
            arm_cnt <= arm_cnt_nxt;
        end
    end

`ifdef UART_TX_FIFO_CRLF_EN
    // Staging register holding the LF that follows an inserted CR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage     <= 8'h00;
            stage_vld <= 1'b0;
        end else begin
            stage     <= stage_nxt;
            stage_vld <= stage_vld_nxt;
        end
    end
`endif

    // Registered transmitter interface; tx_data holds until the next send.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_send <= 1'b0;
            tx_data <= 8'h00;
        end else begin
            tx_send <= send_nxt;
            tx_data <= data_nxt;
        end
    end

endmodule
